// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU operation codes,
// opcode classes and the sequencer state encoding (WAIT_STEP exists only with CU_STEP_EN).
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Zero is reserved for "no operation requested" so an idle bus never looks like ADD.
  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SHR, ALU_SHRA, ALU_SHL,
    ALU_ROR, ALU_ROL, ALU_MUL, ALU_DIV, ALU_NEG, ALU_NOT
  } alu_op_e;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_RR, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LDI, CLS_LD, CLS_ST, CLS_HALT
  } op_class_e;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_STEP_EN
    , S_WAIT_STEP
`endif
  } state_e;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode decoder: maps IR[31:27] to an instruction class and the ALU
// operation used during execute. Undefined opcodes decode as nop.
module opcode_class_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic [3:0]     op_class,
  output logic [3:0]     alu_op
);

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_NONE;
    case (opcode)
      OP_ADD:  begin op_class = CLS_RR;     alu_op = ALU_ADD;  end
      OP_SUB:  begin op_class = CLS_RR;     alu_op = ALU_SUB;  end
      OP_AND:  begin op_class = CLS_RR;     alu_op = ALU_AND;  end
      OP_OR:   begin op_class = CLS_RR;     alu_op = ALU_OR;   end
      OP_SHR:  begin op_class = CLS_RR;     alu_op = ALU_SHR;  end
      OP_SHRA: begin op_class = CLS_RR;     alu_op = ALU_SHRA; end
      OP_SHL:  begin op_class = CLS_RR;     alu_op = ALU_SHL;  end
      OP_ROR:  begin op_class = CLS_RR;     alu_op = ALU_ROR;  end
      OP_ROL:  begin op_class = CLS_RR;     alu_op = ALU_ROL;  end
      OP_ADDI: begin op_class = CLS_IMM;    alu_op = ALU_ADD;  end
      OP_ANDI: begin op_class = CLS_IMM;    alu_op = ALU_AND;  end
      OP_ORI:  begin op_class = CLS_IMM;    alu_op = ALU_OR;   end
      OP_NEG:  begin op_class = CLS_UNARY;  alu_op = ALU_NEG;  end
      OP_NOT:  begin op_class = CLS_UNARY;  alu_op = ALU_NOT;  end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_op = ALU_MUL;  end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_op = ALU_DIV;  end
      OP_LDI:  begin op_class = CLS_LDI;    alu_op = ALU_ADD;  end
      OP_LD:   begin op_class = CLS_LD;     alu_op = ALU_ADD;  end
      OP_ST:   begin op_class = CLS_ST;     alu_op = ALU_ADD;  end
      OP_HALT: op_class = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: steps fetch/execute micro-cycles T0..T7 and drives
// every datapath strobe. Defining CU_STEP_EN adds the step port and a WAIT_STEP park state.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 5
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  operation,
  output logic        run
`ifdef CU_STEP_EN
  ,
  input  logic        step
`endif
);

`ifdef CU_STEP_EN
  localparam state_e INSTR_DONE = S_WAIT_STEP;
`else
  localparam state_e INSTR_DONE = S_T0;
`endif
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_e     state;
  logic [2:0] wait_cnt;
  logic [3:0] class_bits;
  logic [3:0] alu_bits;
  op_class_e  op_class;
  alu_op_e    alu_op;
  logic       mem_state;
  logic       wait_done;
  logic       unused_ir;

  opcode_class_decode #(.OPW(OPW)) u_decode (
    .opcode   (IR[31 -: OPW]),
    .op_class (class_bits),
    .alu_op   (alu_bits)
  );

  assign op_class  = op_class_e'(class_bits);
  assign alu_op    = alu_op_e'(alu_bits);
  assign unused_ir = ^IR[31-OPW:0];

  // Memory micro-cycles stretch to MEM_WAIT+1 clocks; all other states last one clock.
  assign mem_state = (state == S_T1) ||
                     (state == S_T6 && op_class == CLS_LD) ||
                     (state == S_T7 && op_class == CLS_ST);
  assign wait_done = (wait_cnt == WAIT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else if (mem_state && !wait_done) begin
      wait_cnt <= wait_cnt + 3'd1;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_RST:  state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3:   state <= (op_class == CLS_HALT) ? S_HALT :
                         (op_class == CLS_NOP)  ? INSTR_DONE : S_T4;
        S_T4:   state <= (op_class == CLS_UNARY) ? INSTR_DONE : S_T5;
        S_T5:   state <= (op_class inside {CLS_RR, CLS_IMM, CLS_LDI}) ? INSTR_DONE : S_T6;
        S_T6:   state <= (op_class == CLS_MULDIV) ? INSTR_DONE : S_T7;
        S_T7:   state <= INSTR_DONE;
        S_HALT: state <= S_HALT;
`ifdef CU_STEP_EN
        S_WAIT_STEP: if (step) state <= S_T0;
`endif
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zin_low, Zin_high} = '0;
    {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    operation = ALU_NONE;
    run       = !(state inside {S_RST, S_HALT});
    case (state)
      S_T0: {PCout, MARin, IncPC, Zin_low} = '1;
      S_T1: begin
        {Zlowout, Read, MDRin} = '1;
        PCin = wait_done;
      end
      S_T2: {MDRout, IRin} = '1;
      S_T3: case (op_class)
        CLS_RR, CLS_IMM:        {Grb, Rout, Yin} = '1;
        CLS_UNARY: begin
          {Grb, Rout, Zin_low} = '1;
          operation = alu_op;
        end
        CLS_MULDIV:             {Gra, Rout, Yin} = '1;
        CLS_LDI, CLS_LD, CLS_ST: {Grb, BAout, Yin} = '1;
        default: ;
      endcase
      S_T4: case (op_class)
        CLS_RR: begin
          {Grc, Rout, Zin_low} = '1;
          operation = alu_op;
        end
        CLS_IMM: begin
          {Cout, Zin_low} = '1;
          operation = alu_op;
        end
        CLS_UNARY:  {Zlowout, Gra, Rin} = '1;
        CLS_MULDIV: begin
          {Grb, Rout, Zin_low, Zin_high} = '1;
          operation = alu_op;
        end
        CLS_LDI, CLS_LD, CLS_ST: begin
          {Cout, Zin_low} = '1;
          operation = ALU_ADD;
        end
        default: ;
      endcase
      S_T5: case (op_class)
        CLS_RR, CLS_IMM, CLS_LDI: {Zlowout, Gra, Rin} = '1;
        CLS_MULDIV:               {Zlowout, LOin} = '1;
        CLS_LD, CLS_ST:           {Zlowout, MARin} = '1;
        default: ;
      endcase
      S_T6: case (op_class)
        CLS_MULDIV: {Zhighout, HIin} = '1;
        CLS_LD:     {Read, MDRin} = '1;
        CLS_ST:     {Gra, Rout, MDRin} = '1;
        default: ;
      endcase
      S_T7: case (op_class)
        CLS_LD:  {MDRout, Gra, Rin} = '1;
        CLS_ST:  Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule
